// File: rtl/updown_sweep_ctrl.sv
// Drives a loadable up/down counter through lo->hi->lo triangle sweeps with endpoint dwell and loop count.
// Outputs are combinational decodes of state and cnt_q; done/err are registered one-cycle pulses.
module updown_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int LOOPW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] dwell,
   input  logic [LOOPW-1:0] loops,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_ld,
   output logic [WIDTH-1:0] cnt_d,
   output logic             cnt_u_d,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, INIT, UP, TOP, DOWN, BOT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lo_r, hi_r, dwell_r, dcnt, dcnt_nxt;
   logic [LOOPW-1:0] loops_r, lcnt, lcnt_nxt;
   logic             latch, done_nxt, err_nxt;

   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      lcnt_nxt  = lcnt;
      latch     = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      // The counter has no enable, so "hold" is a reload of its own value.
      cnt_ld    = 1'b1;
      cnt_d     = cnt_q;
      cnt_u_d   = 1'b0;

      if (state == IDLE) begin
         if (start && !stop) begin
            if (lo < hi) begin
               latch     = 1'b1;
               lcnt_nxt  = loops;
               state_nxt = INIT;
            end else begin
               err_nxt = 1'b1;
            end
         end
      end else if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            INIT: begin
               cnt_d     = lo_r;
               state_nxt = UP;
            end
            UP: begin
               if (cnt_q < hi_r) begin
                  cnt_ld  = 1'b0;
                  cnt_u_d = 1'b1;
               end else if (dwell_r == '0) begin
                  cnt_ld    = 1'b0;
                  state_nxt = DOWN;
               end else begin
                  dcnt_nxt  = dwell_r - 1'b1;
                  state_nxt = TOP;
               end
            end
            TOP: begin
               if (dcnt == '0) begin
                  cnt_ld    = 1'b0;
                  state_nxt = DOWN;
               end else begin
                  dcnt_nxt = dcnt - 1'b1;
               end
            end
            DOWN: begin
               if (cnt_q > lo_r) begin
                  cnt_ld = 1'b0;
               end else if (loops_r != '0 && lcnt == LOOPW'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  // loops_r == 0 means run forever, so lcnt is left alone.
                  if (loops_r != '0) lcnt_nxt = lcnt - 1'b1;
                  if (dwell_r == '0) begin
                     cnt_ld    = 1'b0;
                     cnt_u_d   = 1'b1;
                     state_nxt = UP;
                  end else begin
                     dcnt_nxt  = dwell_r - 1'b1;
                     state_nxt = BOT;
                  end
               end
            end
            BOT: begin
               if (dcnt == '0) begin
                  cnt_ld    = 1'b0;
                  cnt_u_d   = 1'b1;
                  state_nxt = UP;
               end else begin
                  dcnt_nxt = dcnt - 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lo_r    <= '0;
         hi_r    <= '0;
         dwell_r <= '0;
         loops_r <= '0;
         dcnt    <= '0;
         lcnt    <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
         lcnt  <= lcnt_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
         if (latch) begin
            lo_r    <= lo;
            hi_r    <= hi;
            dwell_r <= dwell;
            loops_r <= loops;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
